// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, FSM states,
// and a small helper that tells arithmetic ops apart from logical/pass ops.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_ADD    = 3'b011,
    OP_SUB    = 3'b100,
    OP_PASS_A = 3'b101,
    OP_PASS_B = 3'b110,
    OP_NOT_A  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Only ADD and SUB produce meaningful carry/overflow flags.
  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: combines one bit of each operand with the running carry.
// SUB is handled as a + ~b + 1, the +1 coming from the carry preset.
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] op_i,
  output logic       s_o,
  output logic       c_o
);

  logic b_eff;

  // Per-bit result and carry-out for the selected operation.
  always_comb begin
    b_eff = b_i;
    s_o   = 1'b0;
    c_o   = 1'b0;
    case (alu_op_e'(op_i))
      OP_AND:    s_o = a_i & b_i;
      OP_OR:     s_o = a_i | b_i;
      OP_XOR:    s_o = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        b_eff = (alu_op_e'(op_i) == OP_SUB) ? ~b_i : b_i;
        s_o   = a_i ^ b_eff ^ c_i;
        c_o   = (a_i & b_eff) | (c_i & (a_i ^ b_eff));
      end
      OP_PASS_A: s_o = a_i;
      OP_PASS_B: s_o = b_i;
      OP_NOT_A:  s_o = ~a_i;
      default:   s_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_n.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first, and
// publishes result and flags together on completion.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one bit per cycle; busy and sout_valid high
// ST_DONE | result/flags just updated; done high; start accepted again
module serial_alu_n
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             reclk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             sout,
  output logic             sout_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  alu_state_e       state_q, state_d;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sum_bit;
  logic             cout_bit;
  logic [WIDTH-1:0] res_next;

  // The a shift register doubles as the result shift register: each computed
  // bit enters at the MSB as the consumed operand bit leaves at the LSB.
  assign res_next = {sum_bit, a_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == '0);

  serial_alu_slice u_slice (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (carry_q),
    .op_i (op_q),
    .s_o  (sum_bit),
    .c_o  (cout_bit)
  );

  // Next-state decode; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Operand capture, serial shifting, bit down-counter and result publication.
  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      carry_q <= (alu_op_e'(op) == OP_SUB);
      cnt_q   <= CNT_LOAD;
    end else if (state_q == ST_RUN) begin
      a_q     <= res_next;
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      carry_q <= cout_bit;
      cnt_q   <= cnt_q - 1'b1;
      if (last_bit) begin
        result <= res_next;
        zero   <= (res_next == '0);
        carry  <= is_arith(alu_op_e'(op_q)) & cout_bit;
        // carry_q here is the carry into the MSB.
        ovf    <= is_arith(alu_op_e'(op_q)) & (carry_q ^ cout_bit);
      end
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign sout_valid = busy;
  assign sout       = busy & sum_bit;

endmodule

// File: tb/tb_serial_alu_n.sv
// Self-checking bench for serial_alu_n (WIDTH=8): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_alu_n;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         ovf;
  logic         sout;
  logic         sout_valid;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] prev_res = '0;

  serial_alu_n #(.WIDTH(W)) dut (
    .reclk      (clk),
    .rst        (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .op         (op),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry      (carry),
    .zero       (zero),
    .ovf        (ovf),
    .sout       (sout),
    .sout_valid (sout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, carry, result}; zero is derived by the caller.
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: begin
        full = {1'b0, x} + {1'b0, y};
        r = full[W-1:0];
        c = full[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd4: begin
        full = {1'b0, x} + {1'b0, ~y} + 1;
        r = full[W-1:0];
        c = full[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd5: r = x;
      3'd6: r = y;
      default: r = ~x;
    endcase
    return {v, c, r};
  endfunction

  // Called just after a negedge with the DUT in IDLE or DONE. Returns just
  // after the negedge of the DONE cycle. Optionally pulses start mid-RUN.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit inject);
    logic [W+1:0] m;
    m = model(o, x, y);
    start = 1'b1; a = x; b = y; op = o;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    for (int i = 0; i < W; i++) begin
      start = (inject && i == 3);
      #1;
      chk("busy_run", busy, 1'b1);
      chk("sout_valid_run", sout_valid, 1'b1);
      chk("sout_bit", sout, m[i]);
      chk("done_run", done, 1'b0);
      chk("result_hold", result, prev_res);
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("sout_valid_done", sout_valid, 1'b0);
    chk("result", result, m[W-1:0]);
    chk("carry", carry, m[W]);
    chk("ovf", ovf, m[W+1]);
    chk("zero", zero, m[W-1:0] == '0);
    prev_res = m[W-1:0];
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_flags", {carry, zero, ovf}, 3'b000);
    chk("rst_sout", {sout, sout_valid}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd3, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    run_op(3'd4, 8'h05, 8'h07, 1'b0);
    @(negedge clk);
    run_op(3'd3, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    run_op(3'd2, 8'hA5, 8'hFF, 1'b0);
    @(negedge clk);
    // Ignored mid-RUN start, then back-to-back from DONE.
    run_op(3'd3, 8'h12, 8'h34, 1'b1);
    run_op(3'd4, 8'h80, 8'h01, 1'b0);
    @(negedge clk);

    // Reset on the 4th RUN cycle.
    start = 1'b1; a = 8'h33; b = 8'h44; op = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, '0);
    chk("midrst_flags", {carry, zero, ovf}, 3'b000);
    chk("midrst_sout", {sout, sout_valid}, 2'b00);
    prev_res = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 1'b0);
    run_op(3'd7, 8'h0F, 8'h00, 1'b0);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        chk("rand_idle_done", done, 1'b0);
      end
      run_op(ro, ra, rb, $urandom_range(0, 3) == 0);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_alu_n.md
SERIAL_ALU_N -- requirements
Module: serial_alu_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result word width in bits; legal range 2..64.
REQ-002 SHALL have port reclk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, which requests an operation; sampled only when the block is not busy.
REQ-005 SHALL have ports a and b, input, WIDTH each, the operands, sampled on the accepted start edge.
REQ-006 SHALL have port op, input, 3, the operation code, sampled on the accepted start edge.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when result and flags update.
REQ-009 SHALL have port result, output, WIDTH, the registered result, held until the next completion.
REQ-010 SHALL have ports carry, zero and ovf, output, 1 each, the registered flags, held with result.
REQ-011 SHALL have ports sout and sout_valid, output, 1 each: the result bit computed this cycle, LSB first, and its qualifier.

Function
REQ-012 SHALL decode op as follows: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (a-b), 101 PASS A, 110 PASS B, 111 NOT A.
REQ-013 SHALL compute bit-serially, one bit per cycle, LSB first, using a 1-bit carry register between bits.
REQ-014 SHALL initialise the carry register to 0 for ADD and to 1 for SUB; SUB SHALL use the inverted b bit.
REQ-015 SHALL implement FSM IDLE -> RUN on accepted start; RUN -> DONE after WIDTH bit cycles; DONE -> IDLE.
REQ-016 SHALL accept start in IDLE and DONE (back-to-back); start in RUN SHALL be ignored, with no queuing.
REQ-017 SHALL drive busy high in RUN only, and done high in DONE only.
REQ-018 Latency: for start accepted on edge k, RUN SHALL cover edges k+1..k+WIDTH, and done SHALL be high for the cycle after edge k+WIDTH.
REQ-019 SHALL make sout_valid high exactly on the WIDTH RUN cycles, with sout equal to result bit i on RUN cycle i.
REQ-020 For ADD/SUB, carry SHALL be the final carry-out; for SUB, carry=1 means no borrow.
REQ-021 For ADD/SUB, ovf SHALL be signed two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
REQ-022 For logical and pass ops, carry and ovf SHALL be 0.
REQ-023 zero SHALL be 1 if and only if the completed result is all zeros.
REQ-024 result and flags SHALL update only on the edge entering DONE, never partially during RUN.
REQ-025 Carry out of the MSB SHALL NOT wrap into bit 0; the result is modulo 2^WIDTH.

Reset
REQ-026 Asserting rst SHALL immediately force the state to IDLE and set busy, done, sout, sout_valid, result, carry, zero and ovf to 0.
REQ-027 Reset asserted mid-RUN SHALL discard the operation with no done pulse, and the first start after deassertion SHALL be accepted normally.

Structure
REQ-028 Op encodings and FSM state encodings SHALL live in shared package serial_alu_pkg.
REQ-029 The per-bit datapath (a bit, b bit, carry in, op -> sum bit, carry out) SHALL be sub-module serial_alu_slice.
REQ-030 Operand and result storage SHALL be WIDTH-bit shift registers, with a bit counter of $clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-031 ADD a=0xFF, b=0x01 -> done 8 cycles after the start edge; result=0x00, carry=1, zero=1, ovf=0.
REQ-032 SUB a=0x05, b=0x07 -> result=0xFE, carry=0, zero=0, ovf=0; ADD a=0x7F, b=0x01 -> result=0x80, ovf=1.
REQ-033 XOR a=0xA5, b=0xFF -> result=0x5A; sout sequence 0,1,0,1,1,0,1,0 with sout_valid high for exactly 8 cycles.
REQ-034 Start pulsed in RUN with different operands -> ignored, and the original result is produced; start held in the DONE cycle -> the next op is accepted with no idle gap.
REQ-035 rst low on the 4th RUN cycle -> all outputs 0 at once, no done pulse; after release, NOT A a=0x0F -> result=0xF0.
